buffer_pea_xbar: RTL and testbench
==================================

BUFFER_PEA_XBAR -- requirements
Module: buffer_pea_xbar

Interface
REQ-001 Parameter N_BUF, default 33, shall set the number of buffer banks and PE-array input/output lanes.
REQ-002 Parameter N_PE, default 32, shall set the index of the broadcast lane used in dense routes (N_PE < N_BUF).
REQ-003 Parameter DATA_W, default 16, shall set the lane width.
REQ-004 Parameter N_SRC, default 4, shall set the number of controller sources; source 0 is IDLE.
REQ-005 Parameter CTRL_W, default 64, shall set the packed control-word width per source.
REQ-006 Parameter EN_W, default 4, shall set the number of enable bits at CTRL_W LSBs: buf1 r/w, buf2 r/w.
REQ-007 Parameter DRAIN_CYC, default 3, shall set the number of enable-gated cycles before a switch commits.
REQ-008 Ports shall be: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-009 Ports shall be: req_valid in 1, mode-change request; req_ready out 1, request accepted when both high.
REQ-010 Ports shall be: req_src in $clog2(N_SRC), requested source; req_route in 2, requested route (01 AYBZ, 00 AZBY, 11 AYaZ, 10 BYbZ).
REQ-011 Ports shall be: src_ctrl in N_SRC*CTRL_W, packed controller words; ctrl_out out CTRL_W, selected word.
REQ-012 Ports shall be: buf1_rd, buf2_rd in N_BUF*DATA_W; pea_out in N_BUF*DATA_W; pea_in1, pea_in2, buf1_wr, buf2_wr out N_BUF*DATA_W.
REQ-013 Ports shall be: busy out 1, high outside ACTIVE/IDLE; cur_src out, cur_route out 2, committed selection; switch_done out 1, one-cycle pulse.

Function
REQ-014 FSM states shall be IDLE (cur_src==0), ACTIVE, DRAIN, COMMIT.
REQ-015 req_ready shall be high only in IDLE and ACTIVE; a handshake shall latch req_src/req_route into pending registers and enter DRAIN.
REQ-016 A request equal to the committed src and route shall be accepted with no DRAIN, and shall pulse switch_done next cycle.
REQ-017 In DRAIN, ctrl_out shall carry the old source word with its EN_W enable bits forced to 0 for exactly DRAIN_CYC cycles, then the FSM shall go to COMMIT.
REQ-018 COMMIT shall last 1 cycle, update cur_src/cur_route, and pulse switch_done.
REQ-019 After COMMIT, the FSM shall go to IDLE if cur_src==0, else ACTIVE.
REQ-020 In IDLE, ctrl_out shall be all zeros except bit positions listed in the package constant CTRL_IDLE_ONES (dense_adder_reset).
REQ-021 ctrl_out shall be registered: 1-cycle latency from src_ctrl[cur_src].
REQ-022 Data routing shall be registered with 1-cycle latency per cur_route.
REQ-023 AYBZ shall route pea_in1=buf1_rd and pea_in2=buf2_rd.
REQ-024 AZBY shall route pea_in1=buf2_rd and pea_in2=buf1_rd.
REQ-025 AYaZ shall route pea_in1=buf1_rd and every pea_in2 lane=buf1_rd lane N_PE.
REQ-026 BYbZ shall route pea_in1=buf2_rd and every pea_in2 lane=buf2_rd lane N_PE.
REQ-027 In conv routes, buf1_wr/buf2_wr lanes shall be pea_out lanes; in dense routes, every lane shall be pea_out lane N_PE.
REQ-028 An out-of-range req_src (>=N_SRC) shall be treated as 0.
REQ-029 req_valid during DRAIN/COMMIT shall be held off (req_ready=0) with no state change.

Reset
REQ-030 On rst, state shall be IDLE, cur_src=0, cur_route=01, pending registers=0, and the drain counter=0.
REQ-031 On rst, req_ready=1, busy=0, switch_done=0, ctrl_out=IDLE word, and all data outputs=0.
REQ-032 rst asserted mid-DRAIN shall abort the switch with no switch_done pulse.

Configuration
REQ-033 With BUFFER_PEA_XBAR_PIPE_EN defined, a second register stage shall be added on data and ctrl_out (latency 2), with DRAIN extended by 1 cycle.
REQ-034 Without BUFFER_PEA_XBAR_PIPE_EN, latency shall be 1.

Structure
REQ-035 Package buffer_pea_pkg shall hold the route_t enum (AYBZ/AZBY/AYaZ/BYbZ), the xbar_state_t enum, CTRL_IDLE_ONES, and the enable-bit index constants.
REQ-036 Submodule xbar_lane_router (combinational route selection over N_BUF lanes) shall be instantiated once per direction.

Verification
REQ-037 Reset then idle: ctrl_out=IDLE word, pea_in1=0, req_ready=1.
REQ-038 Request src=1 route=01 from IDLE: DRAIN for 3 cycles with enables 0, switch_done at cycle 5 after handshake, then pea_in1 lane k = buf1_rd lane k one cycle later.
REQ-039 In ACTIVE src=2 route=11 with buf1_rd lane 32=0x00A5: every pea_in2 lane=0x00A5, every buf2_wr lane=pea_out lane 32.
REQ-040 req_valid held during DRAIN: req_ready=0, second request accepted only after switch_done.
REQ-041 rst asserted on DRAIN cycle 2: cur_src=0, no switch_done pulse, ctrl_out=IDLE word next cycle.
REQ-042 PIPE_EN build with the REQ-038 sequence: data latency 2, DRAIN 4 cycles.

Source files
------------

// File: rtl/buffer_pea_pkg.sv
// Shared route/state types and control-word constants for the buffer <-> PE-array crossbar.
package buffer_pea_pkg;

    // Conv routes pass lanes straight through; dense routes broadcast lane N_PE.
    typedef enum logic [1:0] {
        AZBY = 2'b00,
        AYBZ = 2'b01,
        BYbZ = 2'b10,
        AYaZ = 2'b11
    } route_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_COMMIT
    } xbar_state_t;

    localparam int EN_BUF1_RD = 0;
    localparam int EN_BUF1_WR = 1;
    localparam int EN_BUF2_RD = 2;
    localparam int EN_BUF2_WR = 3;

    localparam int DENSE_ADDER_RESET_BIT = 8;

    // Bits held high in the control word while no controller owns the array.
    localparam logic [63:0] CTRL_IDLE_ONES = 64'd1 << DENSE_ADDER_RESET_BIT;

    function automatic logic is_dense(route_t r);
        return (r == AYaZ) || (r == BYbZ);
    endfunction

endpackage

// File: rtl/xbar_lane_router.sv
// Combinational lane selection for one direction of the crossbar.
// BCAST_Y also broadcasts lane N_PE onto the Y side in dense routes (write-back direction).
module xbar_lane_router
    import buffer_pea_pkg::*;
#(
    parameter int N_BUF   = 33,
    parameter int N_PE    = 32,
    parameter int DATA_W  = 16,
    parameter bit BCAST_Y = 1'b0
) (
    input  route_t                    route,
    input  logic [N_BUF*DATA_W-1:0]   src_a,
    input  logic [N_BUF*DATA_W-1:0]   src_b,
    output logic [N_BUF*DATA_W-1:0]   out_y,
    output logic [N_BUF*DATA_W-1:0]   out_z
);

    logic [DATA_W-1:0] lane_a;
    logic [DATA_W-1:0] lane_b;

    assign lane_a = src_a[N_PE*DATA_W +: DATA_W];
    assign lane_b = src_b[N_PE*DATA_W +: DATA_W];

    always_comb begin
        out_y = src_a;
        out_z = src_b;
        case (route)
            AYBZ: begin
                out_y = src_a;
                out_z = src_b;
            end
            AZBY: begin
                out_y = src_b;
                out_z = src_a;
            end
            AYaZ: begin
                out_y = BCAST_Y ? {N_BUF{lane_a}} : src_a;
                out_z = {N_BUF{lane_a}};
            end
            BYbZ: begin
                out_y = BCAST_Y ? {N_BUF{lane_b}} : src_b;
                out_z = {N_BUF{lane_b}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/buffer_pea_xbar.sv
// Buffer <-> PE-array crossbar with drained switching between controller sources.
// Define BUFFER_PEA_XBAR_PIPE_EN for a second output register stage (latency 2, one extra drain cycle).
//
// state     | meaning
// ST_IDLE   | committed source is 0, control word is the idle word
// ST_ACTIVE | committed source drives the array
// ST_DRAIN  | old source word with enables cleared while the array empties
// ST_COMMIT | pending selection becomes current, switch_done follows
module buffer_pea_xbar
    import buffer_pea_pkg::*;
#(
    parameter int  N_BUF     = 33,
    parameter int  N_PE      = 32,
    parameter int  DATA_W    = 16,
    parameter int  N_SRC     = 4,
    parameter int  CTRL_W    = 64,
    parameter int  EN_W      = 4,
    parameter int  DRAIN_CYC = 3,
    localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int LANES_W   = N_BUF * DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SRC_W-1:0]        req_src,
    input  logic [1:0]              req_route,
    input  logic [N_SRC*CTRL_W-1:0] src_ctrl,
    output logic [CTRL_W-1:0]       ctrl_out,
    input  logic [LANES_W-1:0]      buf1_rd,
    input  logic [LANES_W-1:0]      buf2_rd,
    input  logic [LANES_W-1:0]      pea_out,
    output logic [LANES_W-1:0]      pea_in1,
    output logic [LANES_W-1:0]      pea_in2,
    output logic [LANES_W-1:0]      buf1_wr,
    output logic [LANES_W-1:0]      buf2_wr,
    output logic                    busy,
    output logic [SRC_W-1:0]        cur_src,
    output logic [1:0]              cur_route,
    output logic                    switch_done
);

`ifdef BUFFER_PEA_XBAR_PIPE_EN
    localparam int DRAIN_LEN = DRAIN_CYC + 1;
`else
    localparam int DRAIN_LEN = DRAIN_CYC;
`endif
    localparam int              CNT_W     = $clog2(DRAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DRAIN_LEN - 1);
    localparam logic [CTRL_W-1:0] IDLE_WORD = CTRL_W'(CTRL_IDLE_ONES);
    localparam logic [CTRL_W-1:0] EN_MASK   = CTRL_W'((64'd1 << EN_W) - 64'd1);

    xbar_state_t       state, state_nxt;
    logic [SRC_W-1:0]  cur_src_q, pend_src, req_src_eff;
    route_t            cur_route_q, pend_route;
    logic [CNT_W-1:0]  drain_cnt;
    logic              switch_done_q;
    logic              hs, same_sel;
    logic [CTRL_W-1:0] cur_word, pend_word, ctrl_nxt, ctrl_q1;
    logic [LANES_W-1:0] rd_y, rd_z, wr_y, wr_z;
    logic [LANES_W-1:0] in1_q1, in2_q1, wr1_q1, wr2_q1;

    assign req_src_eff = (int'(req_src) >= N_SRC) ? '0 : req_src;
    assign req_ready   = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign busy        = !req_ready;
    assign hs          = req_valid && req_ready;
    assign same_sel    = (req_src_eff == cur_src_q) && (route_t'(req_route) == cur_route_q);

    // Source 0 never reads its slot of src_ctrl; it always presents the idle word.
    assign cur_word  = (cur_src_q == '0) ? IDLE_WORD : src_ctrl[int'(cur_src_q)*CTRL_W +: CTRL_W];
    assign pend_word = (pend_src == '0) ? IDLE_WORD : src_ctrl[int'(pend_src)*CTRL_W +: CTRL_W];

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = cur_word;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (hs && !same_sel) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                ctrl_nxt = cur_word & ~EN_MASK;
                if (drain_cnt == '0) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                ctrl_nxt  = pend_word;
                state_nxt = (pend_src == '0) ? ST_IDLE : ST_ACTIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_src_q     <= '0;
            cur_route_q   <= AYBZ;
            pend_src      <= '0;
            pend_route    <= AZBY;
            drain_cnt     <= '0;
            switch_done_q <= 1'b0;
            ctrl_q1       <= IDLE_WORD;
        end else begin
            state         <= state_nxt;
            switch_done_q <= (state == ST_COMMIT) || (hs && same_sel);
            ctrl_q1       <= ctrl_nxt;
            if (hs) begin
                pend_src   <= req_src_eff;
                pend_route <= route_t'(req_route);
                drain_cnt  <= CNT_LOAD;
            end else if (state == ST_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (state == ST_COMMIT) begin
                cur_src_q   <= pend_src;
                cur_route_q <= pend_route;
            end
        end
    end

    xbar_lane_router #(
        .N_BUF(N_BUF), .N_PE(N_PE), .DATA_W(DATA_W), .BCAST_Y(1'b0)
    ) u_rd_router (
        .route(cur_route_q), .src_a(buf1_rd), .src_b(buf2_rd), .out_y(rd_y), .out_z(rd_z)
    );

    xbar_lane_router #(
        .N_BUF(N_BUF), .N_PE(N_PE), .DATA_W(DATA_W), .BCAST_Y(1'b1)
    ) u_wr_router (
        .route(cur_route_q), .src_a(pea_out), .src_b(pea_out), .out_y(wr_y), .out_z(wr_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in1_q1 <= '0;
            in2_q1 <= '0;
            wr1_q1 <= '0;
            wr2_q1 <= '0;
        end else begin
            in1_q1 <= rd_y;
            in2_q1 <= rd_z;
            wr1_q1 <= wr_y;
            wr2_q1 <= wr_z;
        end
    end

`ifdef BUFFER_PEA_XBAR_PIPE_EN
    logic [CTRL_W-1:0]  ctrl_q2;
    logic [LANES_W-1:0] in1_q2, in2_q2, wr1_q2, wr2_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q2 <= IDLE_WORD;
            in1_q2  <= '0;
            in2_q2  <= '0;
            wr1_q2  <= '0;
            wr2_q2  <= '0;
        end else begin
            ctrl_q2 <= ctrl_q1;
            in1_q2  <= in1_q1;
            in2_q2  <= in2_q1;
            wr1_q2  <= wr1_q1;
            wr2_q2  <= wr2_q1;
        end
    end

    assign ctrl_out = ctrl_q2;
    assign pea_in1  = in1_q2;
    assign pea_in2  = in2_q2;
    assign buf1_wr  = wr1_q2;
    assign buf2_wr  = wr2_q2;
`else
    assign ctrl_out = ctrl_q1;
    assign pea_in1  = in1_q1;
    assign pea_in2  = in2_q1;
    assign buf1_wr  = wr1_q1;
    assign buf2_wr  = wr2_q1;
`endif

    assign cur_src     = cur_src_q;
    assign cur_route   = cur_route_q;
    assign switch_done = switch_done_q;

endmodule

// File: tb/tb_buffer_pea_xbar.sv
// Scoreboard bench for buffer_pea_xbar: directed requests queue timed expectations and
// expected commits; a negedge monitor pops and compares them.
module tb_buffer_pea_xbar;
    localparam int N_BUF = 33, N_PE = 32, DATA_W = 16, N_SRC = 4, CTRL_W = 64;
    localparam int BW = N_BUF * DATA_W;
`ifdef BUFFER_PEA_XBAR_PIPE_EN
    localparam int LAT = 2;
    localparam int DR  = 4;
`else
    localparam int LAT = 1;
    localparam int DR  = 3;
`endif
    localparam logic [63:0] IDLE_W = 64'h0000_0000_0000_0100;
    localparam logic [63:0] W0 = 64'hDEAD_BEEF_0BAD_F00F;
    localparam logic [63:0] W1 = 64'h1111_2222_3333_444F;
    localparam logic [63:0] W2 = 64'hAAAA_BBBB_CCCC_DDD5;
    localparam logic [63:0] W3 = 64'h5555_6666_7777_888A;
    localparam logic [63:0] G1 = 64'h1111_2222_3333_4440;
    localparam logic [63:0] G2 = 64'hAAAA_BBBB_CCCC_DDD0;
    localparam logic [63:0] G3 = 64'h5555_6666_7777_8880;

    localparam int S_CTRL = 0, S_IN1 = 1, S_IN2 = 2, S_WR1 = 3, S_WR2 = 4;
    localparam int S_RDY = 5, S_BUSY = 6, S_SRC = 7, S_ROUTE = 8, S_DONE = 9;

    logic clk, rst, req_valid, req_ready, busy, switch_done;
    logic [1:0] req_src, req_route, cur_src, cur_route;
    logic [N_SRC*CTRL_W-1:0] src_ctrl;
    logic [CTRL_W-1:0] ctrl_out;
    logic [BW-1:0] buf1_rd, buf2_rd, pea_out, pea_in1, pea_in2, buf1_wr, buf2_wr;

    buffer_pea_xbar dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_route(req_route), .src_ctrl(src_ctrl), .ctrl_out(ctrl_out),
        .buf1_rd(buf1_rd), .buf2_rd(buf2_rd), .pea_out(pea_out),
        .pea_in1(pea_in1), .pea_in2(pea_in2), .buf1_wr(buf1_wr), .buf2_wr(buf2_wr),
        .busy(busy), .cur_src(cur_src), .cur_route(cur_route), .switch_done(switch_done)
    );

    typedef struct { int c; int sig; logic [BW-1:0] v; } chk_t;
    typedef struct { logic [1:0] src; logic [1:0] route; } sw_t;
    chk_t chk_q[$];
    sw_t  sw_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [BW-1:0] pat(logic [15:0] base);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < N_BUF; k++) v[k*DATA_W +: DATA_W] = base + 16'(k);
        return v;
    endfunction

    function automatic logic [BW-1:0] get_sig(int sig);
        case (sig)
            S_CTRL:  return BW'(ctrl_out);
            S_IN1:   return pea_in1;
            S_IN2:   return pea_in2;
            S_WR1:   return buf1_wr;
            S_WR2:   return buf2_wr;
            S_RDY:   return BW'(req_ready);
            S_BUSY:  return BW'(busy);
            S_SRC:   return BW'(cur_src);
            S_ROUTE: return BW'(cur_route);
            S_DONE:  return BW'(switch_done);
            default: return '0;
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            S_CTRL:  return "ctrl_out";
            S_IN1:   return "pea_in1";
            S_IN2:   return "pea_in2";
            S_WR1:   return "buf1_wr";
            S_WR2:   return "buf2_wr";
            S_RDY:   return "req_ready";
            S_BUSY:  return "busy";
            S_SRC:   return "cur_src";
            S_ROUTE: return "cur_route";
            S_DONE:  return "switch_done";
            default: return "unknown";
        endcase
    endfunction

    task automatic exp_v(int c, int sig, logic [BW-1:0] v);
        chk_t e;
        e.c = c; e.sig = sig; e.v = v;
        chk_q.push_back(e);
    endtask

    task automatic exp_s(int c, int sig, logic [63:0] v);
        exp_v(c, sig, BW'(v));
    endtask

    task automatic exp_sw(logic [1:0] s, logic [1:0] r);
        sw_t e;
        e.src = s; e.route = r;
        sw_q.push_back(e);
    endtask

    task automatic go_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: timed expectations plus commit scoreboard keyed on switch_done.
    always @(negedge clk) begin
        logic [BW-1:0] act;
        sw_t e;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].c == cyc) begin
                act = get_sig(chk_q[i].sig);
                n_checks++;
                if (act !== chk_q[i].v) begin
                    n_errors++;
                    $display("FAIL %s cyc %0d: got %h expected %h",
                             sig_name(chk_q[i].sig), cyc, act, chk_q[i].v);
                end
                chk_q.delete(i);
            end
        end
        if (switch_done === 1'b1) begin
            n_checks++;
            if (sw_q.size() == 0) begin
                n_errors++;
                $display("FAIL commit cyc %0d: got unexpected switch_done src=%0d route=%b expected none",
                         cyc, cur_src, cur_route);
            end else begin
                e = sw_q.pop_front();
                if (cur_src !== e.src || cur_route !== e.route) begin
                    n_errors++;
                    $display("FAIL commit cyc %0d: got src=%0d route=%b expected src=%0d route=%b",
                             cyc, cur_src, cur_route, e.src, e.route);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, t, hb, hc, hd, he, hg, hf;
        logic [BW-1:0] b1;

        rst = 1'b1; req_valid = 1'b0; req_src = 2'd0; req_route = 2'b00;
        buf1_rd = '0; buf2_rd = '0; pea_out = '0;
        src_ctrl = {W3, W2, W1, W0};

        exp_s(2, S_CTRL, IDLE_W);  exp_v(2, S_IN1, '0);   exp_v(2, S_WR2, '0);
        exp_s(2, S_RDY, 64'd1);    exp_s(2, S_BUSY, 64'd0);
        exp_s(2, S_SRC, 64'd0);    exp_s(2, S_ROUTE, 64'd1); exp_s(2, S_DONE, 64'd0);
        go_to(3);
        rst = 1'b0;
        exp_s(5, S_CTRL, IDLE_W);  exp_v(5, S_IN1, '0);   exp_s(5, S_RDY, 64'd1);

        // Idle still routes per the reset route AYBZ.
        go_to(6);
        buf1_rd = pat(16'h1000); buf2_rd = pat(16'h2000); pea_out = pat(16'h3000);
        exp_v(6 + LAT - 1, S_IN1, '0);
        exp_v(6 + LAT, S_IN1, pat(16'h1000)); exp_v(6 + LAT, S_IN2, pat(16'h2000));
        exp_v(6 + LAT, S_WR1, pat(16'h3000)); exp_v(6 + LAT, S_WR2, pat(16'h3000));

        // IDLE -> src1/AYBZ
        h = 10;
        go_to(h);
        req_valid = 1'b1; req_src = 2'd1; req_route = 2'b01;
        exp_s(h + 1, S_BUSY, 64'd1); exp_s(h + 1, S_RDY, 64'd0);
        for (int i = 1; i <= DR; i++) exp_s(h + LAT + i, S_CTRL, IDLE_W);
        exp_s(h + DR + 1, S_SRC, 64'd0);
        exp_s(h + DR + 2, S_DONE, 64'd1); exp_s(h + DR + 2, S_BUSY, 64'd0);
        exp_s(h + DR + 3, S_DONE, 64'd0);
        exp_s(h + DR + 1 + LAT, S_CTRL, W1);
        exp_sw(2'd1, 2'b01);
        go_to(h + 1);
        req_valid = 1'b0;
        t = h + DR + 2;
        go_to(t);
        buf1_rd = pat(16'h4000);
        exp_v(t + LAT - 1, S_IN1, pat(16'h1000));
        exp_v(t + LAT, S_IN1, pat(16'h4000));

        // ACTIVE src1 -> src2/AYaZ with buf1 lane 32 = 0x00A5
        hb = h + DR + 6;
        go_to(hb);
        b1 = pat(16'h4000);
        b1[N_PE*DATA_W +: DATA_W] = 16'h00A5;
        buf1_rd = b1;
        req_valid = 1'b1; req_src = 2'd2; req_route = 2'b11;
        for (int i = 1; i <= DR; i++) exp_s(hb + LAT + i, S_CTRL, G1);
        exp_s(hb + DR + 1 + LAT, S_CTRL, W2);
        exp_v(hb + DR + 1 + LAT, S_IN2, pat(16'h2000));
        exp_v(hb + DR + 2 + LAT, S_IN1, b1);
        exp_v(hb + DR + 2 + LAT, S_IN2, {N_BUF{16'h00A5}});
        exp_v(hb + DR + 2 + LAT, S_WR1, {N_BUF{16'h3020}});
        exp_v(hb + DR + 2 + LAT, S_WR2, {N_BUF{16'h3020}});
        exp_sw(2'd2, 2'b11);
        go_to(hb + 1);
        req_valid = 1'b0;

        // Held request: src3/AZBY, then src2/BYbZ waits through the drain
        hc = hb + DR + 6;
        hd = hc + DR + 2;
        go_to(hc);
        req_valid = 1'b1; req_src = 2'd3; req_route = 2'b00;
        for (int i = 1; i <= DR + 1; i++) exp_s(hc + i, S_RDY, 64'd0);
        exp_s(hc + DR + 2, S_RDY, 64'd1); exp_s(hc + DR + 2, S_DONE, 64'd1);
        exp_s(hd + 1, S_BUSY, 64'd1);
        for (int i = 1; i <= DR; i++) exp_s(hc + LAT + i, S_CTRL, G2);
        exp_s(hc + DR + 1 + LAT, S_CTRL, W3);
        exp_v(hc + DR + 2 + LAT, S_IN1, pat(16'h2000));
        exp_v(hc + DR + 2 + LAT, S_IN2, b1);
        exp_v(hc + DR + 2 + LAT, S_WR1, pat(16'h3000));
        for (int i = 1; i <= DR; i++) exp_s(hd + LAT + i, S_CTRL, G3);
        exp_s(hd + DR + 1 + LAT, S_CTRL, W2);
        exp_v(hd + DR + 2 + LAT, S_IN1, pat(16'h2000));
        exp_v(hd + DR + 2 + LAT, S_IN2, {N_BUF{16'h2020}});
        exp_v(hd + DR + 2 + LAT, S_WR2, {N_BUF{16'h3020}});
        exp_sw(2'd3, 2'b00);
        exp_sw(2'd2, 2'b10);
        go_to(hc + 1);
        req_src = 2'd2; req_route = 2'b10;
        go_to(hd + 1);
        req_valid = 1'b0;

        // Same selection: immediate pulse, no drain
        he = hd + DR + 6;
        go_to(he);
        req_valid = 1'b1; req_src = 2'd2; req_route = 2'b10;
        exp_s(he + 1, S_DONE, 64'd1); exp_s(he + 1, S_BUSY, 64'd0); exp_s(he + 1, S_RDY, 64'd1);
        exp_s(he + 2, S_DONE, 64'd0); exp_s(he + 2, S_CTRL, W2);
        exp_sw(2'd2, 2'b10);
        go_to(he + 1);
        req_valid = 1'b0;

        // Back to IDLE
        hg = he + 4;
        go_to(hg);
        req_valid = 1'b1; req_src = 2'd0; req_route = 2'b01;
        for (int i = 1; i <= DR; i++) exp_s(hg + LAT + i, S_CTRL, G2);
        exp_s(hg + DR + 1 + LAT, S_CTRL, IDLE_W);
        exp_sw(2'd0, 2'b01);
        go_to(hg + 1);
        req_valid = 1'b0;

        // Reset on drain cycle 2 aborts the switch
        hf = hg + DR + 6;
        go_to(hf);
        req_valid = 1'b1; req_src = 2'd1; req_route = 2'b00;
        exp_s(hf + 2, S_BUSY, 64'd1);
        exp_s(hf + 3, S_SRC, 64'd0);  exp_s(hf + 3, S_ROUTE, 64'd1);
        exp_s(hf + 3, S_CTRL, IDLE_W); exp_s(hf + 3, S_BUSY, 64'd0);
        exp_s(hf + 3, S_RDY, 64'd1);  exp_v(hf + 3, S_IN1, '0);
        exp_s(hf + 3, S_DONE, 64'd0); exp_s(hf + DR + 2, S_DONE, 64'd0);
        go_to(hf + 1);
        req_valid = 1'b0;
        go_to(hf + 2);
        rst = 1'b1;
        go_to(hf + 3);
        rst = 1'b0;

        go_to(hf + 12);
        n_checks++;
        if (chk_q.size() != 0 || sw_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending: got %0d checks and %0d commits outstanding expected 0 and 0",
                     chk_q.size(), sw_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
